led_pattern_master: RTL
=======================

Name: led_pattern_master

Overview:
- Fabric-side Avalon-MM initiator that drives the HPS-side LED and switch PIO responders from the FPGA fabric.
- Periodically reads the 4-bit switch PIO data register, then computes an 8-bit LED pattern from the switch value and writes it to the LED PIO data register.
- Connects to an Avalon-MM master port of the system interconnect, alongside the HPS.

Parameters:
- ADDR_W, 32, Avalon address width (byte addresses).
- SW_BASE, 32'h0000_0010, byte address of the switch PIO data register.
- LED_BASE, 32'h0000_0000, byte address of the LED PIO data register.
- POLL_CYCLES, 5_000_000, clk_clk cycles between poll starts; must be at least 8.
- TIMEOUT_CYCLES, 1024, bus timeout; used only with LED_PATTERN_TIMEOUT_EN.

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- enable  in  1  polling enabled when high
- avm_address  out  ADDR_W  byte address
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_writedata  out  32  write data; bits [31:8] are 0
- avm_byteenable  out  4  always 4'hF
- avm_readdata  in  32  read data; only bits [3:0] are used
- avm_waitrequest  in  1  responder stall
- avm_readdatavalid  in  1  read data valid
- mode_o  out  2  current pattern mode
- busy_o  out  1  high whenever the state is not IDLE
- err_o  out  1  sticky timeout flag; constant 0 without the optional feature

Behaviour:
- Reset values (async, all outputs): avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, mode_o=0, busy_o=0, err_o=0, pattern=8'h00, direction=up, poll counter=0, divider=0, state=IDLE.
- Poll counter:
  - Counts while enable=1 and wraps at POLL_CYCLES-1; the wrap produces a one-cycle tick.
  - enable=0 clears the counter.
  - A tick that occurs while not in IDLE is dropped.
- State machine:
  - IDLE -> RD_REQ on tick.
  - RD_REQ: avm_read=1, avm_address=SW_BASE. Address and read are held stable while avm_waitrequest=1. On the first cycle with waitrequest=0, go to RD_WAIT and deassert read.
  - RD_WAIT: on avm_readdatavalid, capture sw=avm_readdata[3:0], compute the next pattern, go to WR_REQ.
  - WR_REQ: avm_write=1, avm_address=LED_BASE, avm_writedata={24'h0, pattern}. All held stable while waitrequest=1. On the first cycle with waitrequest=0, go to IDLE.
- readdatavalid arriving in the same cycle that the read is accepted is legal: capture it and go directly to WR_REQ.
- Pattern rules (sw[1:0] = mode, sw[3:2] = speed):
  - Mode change versus mode_o: load the seed (mode0 = {sw,sw}, mode1 = 8'h01, mode2 = 8'h00, mode3 = 8'h01 with direction up), clear the divider, update mode_o. The seed is written this poll.
  - Same mode: the divider counts polls. The pattern advances only when divider == sw[3:2]; the divider then clears. Otherwise the pattern is rewritten unchanged.
  - mode0: pattern = {sw,sw} on every poll; the divider has no effect.
  - mode1: rotate left; 8'h80 -> 8'h01.
  - mode2: increment modulo 256; 8'hFF -> 8'h00.
  - mode3: shift one-hot in the current direction; at 8'h80 the direction flips to down, at 8'h01 it flips to up. Sequence: 01, 02, …, 80, 40, …, 01, 02.
- enable deasserted mid-transaction: the current transaction completes; no new tick is generated.
- Async reset mid-transaction: strobes drop immediately; the interconnect tolerates an abandoned request.

Optional Feature:
- LED_PATTERN_TIMEOUT_EN defined:
  - A per-state counter runs in RD_REQ, RD_WAIT and WR_REQ.
  - Reaching TIMEOUT_CYCLES deasserts strobes, sets err_o=1 (sticky until reset) and returns to IDLE without writing.
  - pattern and mode_o are unchanged by an aborted poll.
- Undefined: the block waits forever and err_o is tied to 0.

Decomposition:
- Package led_pattern_pkg holds:
  - state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ);
  - mode enum (MODE_STATIC, MODE_SHIFT, MODE_COUNT, MODE_BOUNCE);
  - seed constants.
- Sub-module led_pattern_gen: registered pattern/direction/divider/mode. Inputs: sw and an update strobe. Output: pattern. The FSM and bus logic stay in the top.

Test Plan:
- Switch 4'b0101 (mode1, speed1), zero-wait responder, POLL_CYCLES=8 -> write sequence 01,01,02,02,04,…; each write carries byteenable 4'hF and address LED_BASE.
- Mode3, speed0 over 16 polls -> 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01,02.
- Mode2 preloaded near wrap -> FF followed by 00; then switch to 4'b1100 (mode0) -> next write is 8'hCC.
- Responder with waitrequest held 5 cycles and readdatavalid 3 cycles after accept -> address and strobes stay stable throughout; exactly one read then one write per tick; busy_o high for the whole span.
- Responder never returns readdatavalid, LED_PATTERN_TIMEOUT_EN defined, TIMEOUT_CYCLES=16 -> err_o rises 16 cycles into RD_WAIT, no write is issued, next tick retries.
- reset_reset_n pulsed low during WR_REQ -> avm_write=0 in the same cycle; all outputs return to reset values; after release the first write is the seed of the sampled mode.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern master: FSM states, pattern modes and seeds.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SHIFT  = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_e;

    localparam logic       DIR_UP      = 1'b0;
    localparam logic       DIR_DOWN    = 1'b1;
    localparam logic [7:0] SEED_SHIFT  = 8'h01;
    localparam logic [7:0] SEED_COUNT  = 8'h00;
    localparam logic [7:0] SEED_BOUNCE = 8'h01;

    // Static mode shows the switch nibble on both halves of the LED bar.
    function automatic logic [7:0] static_pattern(input logic [3:0] sw);
        return {sw, sw};
    endfunction

endpackage

// File: rtl/led_pattern_gen.sv
// Pattern generator: holds pattern, direction, poll divider and mode; commits the next
// pattern (computed from the captured switch value) only when update_i is pulsed.
module led_pattern_gen
    import led_pattern_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [3:0] sw_i,
    input  logic       update_i,
    output logic [7:0] pattern_o,
    output logic [1:0] mode_o
);

    logic [7:0] pattern_q, pattern_d;
    logic       dir_q, dir_d;
    logic [1:0] div_q, div_d;
    mode_e      mode_q, mode_d;

    mode_e      sw_mode;
    logic [1:0] speed;
    logic       bounce_dir;

    assign sw_mode = mode_e'(sw_i[1:0]);
    assign speed   = sw_i[3:2];

    // The bounce direction turns around at either end before shifting.
    always_comb begin
        bounce_dir = dir_q;
        if (pattern_q == 8'h80) begin
            bounce_dir = DIR_DOWN;
        end else if (pattern_q == 8'h01) begin
            bounce_dir = DIR_UP;
        end
    end

    always_comb begin
        pattern_d = pattern_q;
        dir_d     = dir_q;
        div_d     = div_q;
        mode_d    = mode_q;
        if (sw_mode != mode_q) begin
            mode_d = sw_mode;
            div_d  = 2'd0;
            dir_d  = DIR_UP;
            unique case (sw_mode)
                MODE_STATIC: pattern_d = static_pattern(sw_i);
                MODE_SHIFT:  pattern_d = SEED_SHIFT;
                MODE_COUNT:  pattern_d = SEED_COUNT;
                MODE_BOUNCE: pattern_d = SEED_BOUNCE;
                default:     pattern_d = pattern_q;
            endcase
        end else if (sw_mode == MODE_STATIC) begin
            pattern_d = static_pattern(sw_i);
        end else if (div_q == speed) begin
            div_d = 2'd0;
            unique case (sw_mode)
                MODE_SHIFT: pattern_d = {pattern_q[6:0], pattern_q[7]};
                MODE_COUNT: pattern_d = pattern_q + 8'd1;
                MODE_BOUNCE: begin
                    dir_d     = bounce_dir;
                    pattern_d = (bounce_dir == DIR_UP) ? {pattern_q[6:0], 1'b0}
                                                       : {1'b0, pattern_q[7:1]};
                end
                default: pattern_d = pattern_q;
            endcase
        end else begin
            div_d = div_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pattern_q <= 8'h00;
            dir_q     <= DIR_UP;
            div_q     <= 2'd0;
            mode_q    <= MODE_STATIC;
        end else if (update_i) begin
            pattern_q <= pattern_d;
            dir_q     <= dir_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
        end
    end

    // The value presented is what the next write will carry.
    assign pattern_o = pattern_d;
    assign mode_o    = mode_q;

endmodule

// File: rtl/led_pattern_master.sv
// Avalon-MM initiator that polls the switch PIO and writes an LED pattern to the LED PIO.
// Define LED_PATTERN_TIMEOUT_EN to enable the per-state bus timeout and the sticky err_o flag.
module led_pattern_master
    import led_pattern_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] SW_BASE        = 'h10,
    parameter logic [ADDR_W-1:0] LED_BASE       = 'h0,
    parameter int unsigned       POLL_CYCLES    = 5_000_000,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    input  logic              avm_readdatavalid,
    output logic [1:0]        mode_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned PW = $clog2(POLL_CYCLES);

    state_e      state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [3:0]  sw_q, sw_d;
    logic        tick;
    logic        gen_update;
    logic        timeout;
    logic [7:0]  pattern;
    logic        readdata_unused;

    assign readdata_unused = ^avm_readdata[31:4];

    // Poll timer: free-runs while enabled, one-cycle tick on wrap.
    assign tick = enable && (poll_q == PW'(POLL_CYCLES - 1));

    always_comb begin
        poll_d = poll_q + 1'b1;
        if (!enable || tick) begin
            poll_d = '0;
        end
    end

    // Ticks outside IDLE fall through unused, which drops them.
    always_comb begin
        state_d    = state_q;
        sw_d       = sw_q;
        gen_update = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (!avm_waitrequest) begin
                    if (avm_readdatavalid) begin
                        sw_d    = avm_readdata[3:0];
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (avm_readdatavalid) begin
                    sw_d    = avm_readdata[3:0];
                    state_d = WR_REQ;
                end
            end
            WR_REQ: begin
                if (!avm_waitrequest) begin
                    gen_update = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout) begin
            state_d    = IDLE;
            gen_update = 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= IDLE;
            poll_q  <= '0;
            sw_q    <= 4'h0;
        end else begin
            state_q <= state_d;
            poll_q  <= poll_d;
            sw_q    <= sw_d;
        end
    end

`ifdef LED_PATTERN_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    assign timeout = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // The timer restarts on every state change so each bus phase gets its own budget.
    always_comb begin
        tmo_d = tmo_q + 1'b1;
        if (state_q == IDLE || state_d != state_q) begin
            tmo_d = '0;
        end
        err_d = err_q | timeout;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    localparam int unsigned tmo_unused = TIMEOUT_CYCLES;

    assign timeout = 1'b0;
    assign err_o   = 1'b0;
`endif

    led_pattern_gen u_gen (
        .clk_i     (clk_clk),
        .rst_ni    (reset_reset_n),
        .sw_i      (sw_q),
        .update_i  (gen_update),
        .pattern_o (pattern),
        .mode_o    (mode_o)
    );

    // Bus strobes decode straight from the state register, so they hold while stalled
    // and drop the moment reset is asserted.
    always_comb begin
        avm_read      = 1'b0;
        avm_write     = 1'b0;
        avm_address   = '0;
        avm_writedata = 32'h0;
        unique case (state_q)
            RD_REQ: begin
                avm_read    = 1'b1;
                avm_address = SW_BASE;
            end
            WR_REQ: begin
                avm_write     = 1'b1;
                avm_address   = LED_BASE;
                avm_writedata = {24'h0, pattern};
            end
            default: ;
        endcase
    end

    assign avm_byteenable = 4'hF;
    assign busy_o         = (state_q != IDLE);

endmodule
